// File: rtl/tweakey_schedule_pkg.sv
// Shared types, widths and byte-level helpers for the SKINNY-128-384+ tweakey schedule.
// Byte 0 of a tweakey occupies bits 127:120.
package tweakey_schedule_pkg;

    localparam int TK_W      = 128;
    localparam int RK_W      = 64;
    localparam int RND_W     = 6;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = TK_W / BYTE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Source byte index for each destination byte of the tweakey permutation PT.
    localparam int PT_MAP [NUM_BYTES] = '{9, 15, 8, 13, 10, 14, 12, 11,
                                          0,  1, 2,  3,  4,  5,  6,  7};

    function automatic logic [TK_W-1:0] pt_perm(input logic [TK_W-1:0] tk);
        logic [TK_W-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            res[TK_W-1-BYTE_W*i -: BYTE_W] = tk[TK_W-1-BYTE_W*PT_MAP[i] -: BYTE_W];
        end
        return res;
    endfunction

    function automatic logic [BYTE_W-1:0] lfsr2(input logic [BYTE_W-1:0] b);
        return {b[6:0], b[7] ^ b[5]};
    endfunction

    function automatic logic [BYTE_W-1:0] lfsr3(input logic [BYTE_W-1:0] b);
        return {b[0] ^ b[6], b[7:1]};
    endfunction

endpackage

// File: rtl/tk3_expansion.sv
// TK3 update for one share: tweakey permutation followed by LFSR3 on bytes 0..7.
// Both steps are linear, so each share is updated on its own without any refresh.
module tk3_expansion
    import tweakey_schedule_pkg::*;
(
    input  logic [TK_W-1:0] tk,
    output logic [TK_W-1:0] tk_next
);

    logic [TK_W-1:0] permuted;

    always_comb begin
        permuted = pt_perm(tk);
        tk_next  = permuted;
        for (int i = 0; i < NUM_BYTES / 2; i++) begin
            tk_next[TK_W-1-BYTE_W*i -: BYTE_W] = lfsr3(permuted[TK_W-1-BYTE_W*i -: BYTE_W]);
        end
    end

endmodule

// File: rtl/tweak_expansion.sv
// TK2 update: tweakey permutation followed by LFSR2 on the top half (bytes 0..7).
module tweak_expansion
    import tweakey_schedule_pkg::*;
(
    input  logic [TK_W-1:0] tk,
    output logic [TK_W-1:0] tk_next
);

    logic [TK_W-1:0] permuted;

    always_comb begin
        permuted = pt_perm(tk);
        tk_next  = permuted;
        for (int i = 0; i < NUM_BYTES / 2; i++) begin
            tk_next[TK_W-1-BYTE_W*i -: BYTE_W] = lfsr2(permuted[TK_W-1-BYTE_W*i -: BYTE_W]);
        end
    end

endmodule

// File: rtl/tweakey_schedule.sv
// Sequential tweakey schedule for the DOM-1 SKINNY-128-384+ core: holds TK1, TK2 and a
// 2-share TK3 and hands one masked round key per round to the round function.
module tweakey_schedule
    import tweakey_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TK_W-1:0]  tk1_i,
    input  logic [TK_W-1:0]  tk2_i,
    input  logic [TK_W-1:0]  tk3_s0_i,
    input  logic [TK_W-1:0]  tk3_s1_i,
    output logic             ready_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [RK_W-1:0]  rk_s0_o,
    output logic [RK_W-1:0]  rk_s1_o,
    output logic [RND_W-1:0] round_o,
    output logic             done_o
);

    // Handshake: a round key moves when rk_valid_o && rk_ready_i at a rising edge; while
    // rk_valid_o is high and rk_ready_i is low every register holds. A load is taken only
    // when ready_o is high.

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);

    state_e          state_q;
    logic [TK_W-1:0] tk1_q, tk2_q, tk3_s0_q, tk3_s1_q;
    logic [TK_W-1:0] tk1_next, tk2_next, tk3_s0_next, tk3_s1_next;
    logic [RND_W-1:0] round_q;
    logic            done_q;
    logic [TK_W-1:0] share0_full;

    assign tk1_next = pt_perm(tk1_q);

    tweak_expansion u_tk2_exp (
        .tk      (tk2_q),
        .tk_next (tk2_next)
    );

    tk3_expansion u_tk3_s0_exp (
        .tk      (tk3_s0_q),
        .tk_next (tk3_s0_next)
    );

    tk3_expansion u_tk3_s1_exp (
        .tk      (tk3_s1_q),
        .tk_next (tk3_s1_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tk1_q    <= '0;
            tk2_q    <= '0;
            tk3_s0_q <= '0;
            tk3_s1_q <= '0;
            round_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    round_q <= '0;
                    if (load_i) begin
                        tk1_q    <= tk1_i;
                        tk2_q    <= tk2_i;
                        tk3_s0_q <= tk3_s0_i;
                        tk3_s1_q <= tk3_s1_i;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rk_ready_i) begin
                        tk1_q    <= tk1_next;
                        tk2_q    <= tk2_next;
                        tk3_s0_q <= tk3_s0_next;
                        tk3_s1_q <= tk3_s1_next;
                        if (round_q == LAST_ROUND) begin
                            state_q <= ST_IDLE;
                            round_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            round_q <= round_q + RND_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Only the public TK1/TK2 are folded into share 0; the two TK3 shares never meet.
    assign share0_full = tk1_q ^ tk2_q ^ tk3_s0_q;

    assign ready_o    = (state_q == ST_IDLE);
    assign rk_valid_o = (state_q == ST_BUSY);
    assign rk_s0_o    = rk_valid_o ? share0_full[TK_W-1 -: RK_W] : '0;
    assign rk_s1_o    = rk_valid_o ? tk3_s1_q[TK_W-1 -: RK_W] : '0;
    assign round_o    = round_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_tweakey_schedule.sv
// Self-checking bench for tweakey_schedule: directed vector table plus multi-cycle sequences
// for random schedules, stalls, completion and mid-schedule reset.
module tb_tweakey_schedule;

    logic         clk;
    logic         rst_n;
    logic         load_i;
    logic [127:0] tk1_i, tk2_i, tk3_s0_i, tk3_s1_i;
    logic         ready_o;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic [63:0]  rk_s0_o, rk_s1_o;
    logic [5:0]   round_o;
    logic         done_o;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp1_q[$];
    logic [63:0] pub_q[$];

    typedef struct {
        string        name;
        logic [127:0] tk1, tk2, s0, s1;
        int           rnd;
        logic [63:0]  e0, e1;
    } vec_t;

    vec_t vecs[10];

    tweakey_schedule #(.NUM_ROUNDS(40)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_i),
        .tk1_i      (tk1_i),
        .tk2_i      (tk2_i),
        .tk3_s0_i   (tk3_s0_i),
        .tk3_s1_i   (tk3_s1_i),
        .ready_o    (ready_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .rk_s0_o    (rk_s0_o),
        .rk_s1_o    (rk_s1_o),
        .round_o    (round_o),
        .done_o     (done_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // golden model: byte-array formulation of one schedule step
    function automatic logic [127:0] m_step(input logic [127:0] t, input int kind);
        logic [7:0] b [16];
        logic [7:0] n [16];
        int src [8];
        logic [127:0] r;
        src = '{9, 15, 8, 13, 10, 14, 12, 11};
        for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
        for (int i = 0; i < 8; i++) begin
            n[i]   = b[src[i]];
            n[i+8] = b[i];
        end
        for (int i = 0; i < 8; i++) begin
            if (kind == 2) n[i] = (n[i] << 1) | (((n[i] >> 7) ^ (n[i] >> 5)) & 8'h01);
            if (kind == 3) n[i] = (n[i] >> 1) | (((n[i] ^ (n[i] >> 6)) & 8'h01) << 7);
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = n[i];
        return r;
    endfunction

    // driver tasks
    task automatic do_reset();
        rst_n      = 1'b0;
        load_i     = 1'b0;
        rk_ready_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] c, input logic [127:0] d);
        int budget;
        budget = 0;
        while (!ready_o && budget < 200) begin
            tick();
            budget++;
        end
        check("load_wait_ready", 64'(ready_o), 64'd1);
        tk1_i = a; tk2_i = b; tk3_s0_i = c; tk3_s1_i = d;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic advance(input int n);
        rk_ready_i = 1'b1;
        repeat (n) tick();
        rk_ready_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_valid"}, 64'(rk_valid_o), 64'd0);
        check({tag, "_s0"}, rk_s0_o, 64'd0);
        check({tag, "_s1"}, rk_s1_o, 64'd0);
        check({tag, "_round"}, 64'(round_o), 64'd0);
    endtask

    initial begin
        logic [127:0] m1, m2, m30, m31, r;
        logic [63:0]  e0, e1;
        int budget;

        vecs[0] = '{"t1_r0",  128'h000102030405060708090a0b0c0d0e0f, '0, '0, '0, 0,
                    64'h0001020304050607, 64'h0};
        vecs[1] = '{"t1_r1",  128'h000102030405060708090a0b0c0d0e0f, '0, '0, '0, 1,
                    64'h090f080d0a0e0c0b, 64'h0};
        vecs[2] = '{"t1_r2",  128'h000102030405060708090a0b0c0d0e0f, '0, '0, '0, 2,
                    64'h0107000502060403, 64'h0};
        vecs[3] = '{"tk2_b9", '0, 128'h00000000000000000001000000000000, '0, '0, 1,
                    64'h0200000000000000, 64'h0};
        vecs[4] = '{"tk3s0_b9", '0, '0, 128'h00000000000000000001000000000000, '0, 1,
                    64'h8000000000000000, 64'h0};
        vecs[5] = '{"tk3s1_b9", '0, '0, '0, 128'h00000000000000000001000000000000, 1,
                    64'h0, 64'h8000000000000000};
        vecs[6] = '{"tk2_b0_r2", '0, 128'h80000000000000000000000000000000, '0, '0, 2,
                    64'h0000010000000000, 64'h0};
        vecs[7] = '{"tk3s1_b0_r2", '0, '0, '0, 128'h81000000000000000000000000000000, 2,
                    64'h0, 64'h0000c00000000000};
        vecs[8] = '{"ones_r0", {16{8'hff}}, {16{8'hff}}, '0, '0, 0, 64'h0, 64'h0};
        vecs[9] = '{"ones_r1", {16{8'hff}}, {16{8'hff}}, '0, '0, 1,
                    64'h0101010101010101, 64'h0};

        tk1_i = '0; tk2_i = '0; tk3_s0_i = '0; tk3_s1_i = '0;
        do_reset();
        check_idle("reset");
        check("reset_done", 64'(done_o), 64'd0);

        // directed vector table
        foreach (vecs[v]) begin
            do_reset();
            do_load(vecs[v].tk1, vecs[v].tk2, vecs[v].s0, vecs[v].s1);
            advance(vecs[v].rnd);
            check({vecs[v].name, "_valid"}, 64'(rk_valid_o), 64'd1);
            check({vecs[v].name, "_round"}, 64'(round_o), 64'(vecs[v].rnd));
            check({vecs[v].name, "_s0"}, rk_s0_o, vecs[v].e0);
            check({vecs[v].name, "_s1"}, rk_s1_o, vecs[v].e1);
        end

        // random schedule, equal TK3 shares, random backpressure and ignored loads while busy
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            r  = {$urandom, $urandom, $urandom, $urandom};
            m1 = {$urandom, $urandom, $urandom, $urandom};
            m2 = {$urandom, $urandom, $urandom, $urandom};
            m30 = r; m31 = r;
            for (int k = 0; k < 40; k++) begin
                exp_q.push_back(m1[127:64] ^ m2[127:64] ^ m30[127:64]);
                exp1_q.push_back(m31[127:64]);
                pub_q.push_back(m1[127:64] ^ m2[127:64]);
                m1 = m_step(m1, 1); m2 = m_step(m2, 2);
                m30 = m_step(m30, 3); m31 = m_step(m31, 3);
            end
            do_load(m_step(m1, 1) ^ m1, m2 ^ r, ~r, r);
            // model was advanced 40 steps; reload the true start values
            do_reset();
            m1 = '0;
            begin
                logic [127:0] a, b;
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
                exp_q.delete(); exp1_q.delete(); pub_q.delete();
                m1 = a; m2 = b; m30 = r; m31 = r;
                for (int k = 0; k < 40; k++) begin
                    exp_q.push_back(m1[127:64] ^ m2[127:64] ^ m30[127:64]);
                    exp1_q.push_back(m31[127:64]);
                    pub_q.push_back(m1[127:64] ^ m2[127:64]);
                    m1 = m_step(m1, 1); m2 = m_step(m2, 2);
                    m30 = m_step(m30, 3); m31 = m_step(m31, 3);
                end
                do_load(a, b, r, r);
            end
            budget = 0;
            begin
                int idx;
                idx = 0;
                while (exp_q.size() > 0 && budget < 2000) begin
                    rk_ready_i = 1'($urandom_range(0, 1));
                    load_i = 1'($urandom_range(0, 1));
                    tk1_i = {$urandom, $urandom, $urandom, $urandom};
                    tk3_s0_i = {$urandom, $urandom, $urandom, $urandom};
                    if (rk_valid_o && rk_ready_i) begin
                        e0 = exp_q.pop_front();
                        e1 = exp1_q.pop_front();
                        check("rand_round", 64'(round_o), 64'(idx));
                        check("rand_s0", rk_s0_o, e0);
                        check("rand_s1", rk_s1_o, e1);
                        check("rand_pub", rk_s0_o ^ rk_s1_o, pub_q.pop_front());
                        idx++;
                    end
                    tick();
                    load_i = 1'b0;
                    budget++;
                end
            end
            rk_ready_i = 1'b0;
            check("rand_budget", 64'(exp_q.size()), 64'd0);
            check("done_pulse", 64'(done_o), 64'd1);
            check_idle("after_done");
            tick();
            check("done_single", 64'(done_o), 64'd0);
            check("done_stays_idle", 64'(ready_o), 64'd1);
        end

        // stall at round 5
        do_reset();
        m1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        m2 = 128'h112233445566778899aabbccddeeff00;
        m30 = 128'hdeadbeef0123456789abcdef55aa33cc;
        m31 = 128'h0badf00d76543210fedcba98c3a5965a;
        do_load(m1, m2, m30, m31);
        for (int k = 0; k < 5; k++) begin
            m1 = m_step(m1, 1); m2 = m_step(m2, 2);
            m30 = m_step(m30, 3); m31 = m_step(m31, 3);
        end
        advance(5);
        e0 = m1[127:64] ^ m2[127:64] ^ m30[127:64];
        e1 = m31[127:64];
        for (int k = 0; k < 3; k++) begin
            check("stall_round", 64'(round_o), 64'd5);
            check("stall_s0", rk_s0_o, e0);
            check("stall_s1", rk_s1_o, e1);
            check("stall_valid", 64'(rk_valid_o), 64'd1);
            tick();
        end
        m1 = m_step(m1, 1); m2 = m_step(m2, 2);
        m30 = m_step(m30, 3); m31 = m_step(m31, 3);
        advance(1);
        check("resume_round", 64'(round_o), 64'd6);
        check("resume_s0", rk_s0_o, m1[127:64] ^ m2[127:64] ^ m30[127:64]);
        check("resume_s1", rk_s1_o, m31[127:64]);

        // reset in the middle of a schedule
        do_reset();
        do_load(128'h000102030405060708090a0b0c0d0e0f, '1, '1, '1);
        advance(20);
        check("pre_abort_round", 64'(round_o), 64'd20);
        rst_n = 1'b0;
        tick();
        check_idle("abort");
        check("abort_done", 64'(done_o), 64'd0);
        rst_n = 1'b1;
        tick();
        check("abort_done_after", 64'(done_o), 64'd0);
        check("abort_ready_after", 64'(ready_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
